// File: rtl/decode_issue_buf.sv
// Decode-to-issue skid buffer: a circular first-word-fall-through queue between
// decode and execute, with a global hold, a flush, and a saturating stall counter.
module decode_issue_buf #(
    parameter int                WIDTH  = 128,
    parameter int                DEPTH  = 4,
    parameter logic [WIDTH-1:0]  BUBBLE = '0,
    parameter int                CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     hold,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;
    logic             push;
    logic             pop;
    logic             blocked;

    // Reset, hold and flush all suppress both handshakes for the cycle.
    assign blocked   = Rst || hold || flush;
    assign full      = (occ == OCC_W'(DEPTH));
    assign empty     = (occ == '0);
    assign count     = occ;
    assign out_valid = !empty && !blocked;
    assign out_data  = out_valid ? mem[rd_ptr] : BUBBLE;
    assign in_ready  = !blocked && (!full || out_ready);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (Rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (hold) begin
            rd_ptr <= rd_ptr;
            wr_ptr <= wr_ptr;
            occ    <= occ;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // out_valid is already low under hold and flush, so only real stalls count.
    always_ff @(posedge clk) begin
        if (Rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_issue_buf.sv
// Self-checking bench for decode_issue_buf: a fixed fill/drain vector table,
// directed flush/hold/wrap/saturation/reset sequences, then randomized traffic.
module tb_decode_issue_buf;

    localparam int          WIDTH  = 32;
    localparam int          DEPTH  = 4;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] BUBBLE = 32'h0BAD_F00D;
    localparam int          STALL_MAX = 15;

    logic              clk;
    logic              rst;
    logic              hold;
    logic              flush;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_ready;
    logic [2:0]        count;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of held payloads and a stall tally.
    logic [31:0] model_q[$];
    int          model_stall = 0;
    logic        exp_ov;
    logic        exp_ir;

    typedef struct {
        logic        hold;
        logic        flush;
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        int          exp_count;
        logic        exp_ov;
        logic [31:0] exp_data;
        logic        exp_ir;
        int          exp_stall;
    } vec_t;

    vec_t vecs[11];

    decode_issue_buf #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .BUBBLE (BUBBLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .Rst       (rst),
        .hold      (hold),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output with what the model says for the current inputs.
    task automatic checkOutput();
        int          sz;
        logic [31:0] exp_data;
        sz       = model_q.size();
        exp_ov   = !rst && !hold && !flush && (sz > 0);
        exp_ir   = !rst && !hold && !flush && ((sz < DEPTH) || out_ready);
        exp_data = exp_ov ? model_q[0] : BUBBLE;
        if (!rst) begin
            check_val("out_valid", 64'(out_valid), 64'(exp_ov));
            check_val("out_data",  64'(out_data),  64'(exp_data));
            check_val("in_ready",  64'(in_ready),  64'(exp_ir));
            check_val("count",     64'(count),     64'(sz));
            check_val("full",      64'(full),      64'(sz == DEPTH));
            check_val("empty",     64'(empty),     64'(sz == 0));
            check_val("stall_cnt", 64'(stall_cnt), 64'(model_stall));
        end else begin
            check_val("in_ready_rst", 64'(in_ready), 64'(0));
        end
    endtask

    task automatic applyStimulus(input logic r, input logic h, input logic f, input logic iv,
                                 input logic [31:0] d, input logic ordy);
        @(negedge clk);
        rst       = r;
        hold      = h;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_stall = 0;
        end else if (!hold) begin
            if (exp_ov && !out_ready && (model_stall < STALL_MAX)) begin
                model_stall++;
            end
            if (flush) begin
                model_q.delete();
            end else begin
                if (exp_ov && out_ready) begin
                    void'(model_q.pop_front());
                end
                if (in_valid && exp_ir) begin
                    model_q.push_back(in_data);
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic h, input logic f, input logic iv,
                         input logic [31:0] d, input logic ordy);
        applyStimulus(r, h, f, iv, d, ordy);
        advance();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_q.delete();
        model_stall = 0;

        // Fill to full, blocked push, pass-through at full, then drain.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'hA000_0001, 1'b0, 0, 1'b0, BUBBLE,        1'b1, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'hA000_0002, 1'b0, 1, 1'b1, 32'hA000_0001, 1'b1, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'hA000_0003, 1'b0, 2, 1'b1, 32'hA000_0001, 1'b1, 1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'hA000_0004, 1'b0, 3, 1'b1, 32'hA000_0001, 1'b1, 2};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'hBAD0_0001, 1'b0, 4, 1'b1, 32'hA000_0001, 1'b0, 3};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'hB000_0001, 1'b1, 4, 1'b1, 32'hA000_0001, 1'b1, 4};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 4, 1'b1, 32'hA000_0002, 1'b1, 4};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 3, 1'b1, 32'hA000_0003, 1'b1, 4};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 2, 1'b1, 32'hA000_0004, 1'b1, 4};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1, 1'b1, 32'hB000_0001, 1'b1, 4};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 0, 1'b0, BUBBLE,        1'b1, 4};

        $display("[TB] reset state and fill/drain table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, vecs[i].hold, vecs[i].flush, vecs[i].in_valid,
                          vecs[i].in_data, vecs[i].out_ready);
            check_val($sformatf("tbl%0d_count", i), 64'(count),     64'(vecs[i].exp_count));
            check_val($sformatf("tbl%0d_ov", i),    64'(out_valid), 64'(vecs[i].exp_ov));
            check_val($sformatf("tbl%0d_data", i),  64'(out_data),  64'(vecs[i].exp_data));
            check_val($sformatf("tbl%0d_ir", i),    64'(in_ready),  64'(vecs[i].exp_ir));
            check_val($sformatf("tbl%0d_stall", i), 64'(stall_cnt), 64'(vecs[i].exp_stall));
            advance();
        end

        $display("[TB] flush with same-cycle push");
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hC000_0000 + 32'(i), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_0001, 1'b1);
        check_val("flush_ir", 64'(in_ready), 64'(0));
        check_val("flush_ov", 64'(out_valid), 64'(0));
        advance();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hF000_0001, 1'b0);
        check_val("post_flush_count", 64'(count), 64'(0));
        check_val("post_flush_data", 64'(out_data), 64'(BUBBLE));
        advance();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hF000_0002, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_val("post_flush_head1", 64'(out_data), 64'(32'hF000_0001));
        advance();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_val("post_flush_head2", 64'(out_data), 64'(32'hF000_0002));
        advance();

        $display("[TB] hold freezes everything");
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hD000_0001, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hD000_0002, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hEEEE_0000 + 32'(i), 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_val("hold_head", 64'(out_data), 64'(32'hD000_0001));
        check_val("hold_count", 64'(count), 64'(2));
        check_val("hold_stall", 64'(stall_cnt), 64'(1));
        advance();

        $display("[TB] wrap-around at occupancy one");
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h5000_0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h5000_0001 + 32'(i), 1'b1);
            check_val($sformatf("wrap%0d_data", i), 64'(out_data), 64'(32'h5000_0000 + 32'(i)));
            advance();
        end

        $display("[TB] stall saturation then mid-stream reset");
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h6000_0001, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h6000_0002, 1'b0);
        check_val("sat_stall", 64'(stall_cnt), 64'(STALL_MAX));
        advance();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h6000_0003, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_val("rst_count", 64'(count), 64'(0));
        check_val("rst_stall", 64'(stall_cnt), 64'(0));
        check_val("rst_data", 64'(out_data), 64'(BUBBLE));
        advance();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                  $urandom, $urandom_range(0, 9) < 5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
